// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage integer pipeline: load-use bubbles, redirect flushes and refill, multi-cycle EX and slow-memory freezes.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise the counter ports are tied to zero.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FETCH_LATENCY  = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_address,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_address,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_address,
    input  logic                      ex_reg_wren,
    input  logic                      ex_is_load,
    input  logic                      ex_redirect,
    input  logic                      ex_mc_start,
    input  logic                      ex_mc_done,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_wren,
    output logic                      if_id_wren,
    output logic                      id_ex_wren,
    output logic                      ex_mem_wren,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic [CNT_WIDTH-1:0]      perf_stall_cnt,
    output logic [CNT_WIDTH-1:0]      perf_flush_cnt
);

    localparam int RCW = (FETCH_LATENCY > 0) ? $clog2(FETCH_LATENCY + 1) : 1;

    typedef enum logic [1:0] {RUN, REFILL, MC_WAIT, MEM_WAIT} state_t;

    state_t         state, state_nxt;
    logic [RCW-1:0] refill_cnt, refill_cnt_nxt;
    logic           mc_taken, mc_taken_nxt;
    logic           lu_block, lu_block_nxt;

    logic mem_stall, released, mc_ok, hazard, lu_taken, refill_active;
    logic pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f;

    assign mem_stall     = mem_req & ~mem_ready;
    assign refill_active = (refill_cnt != '0);
    assign hazard = ex_is_load & ex_reg_wren & (ex_rd_address != '0) &
                    ((id_uses_rs1 & (id_rs1_address == ex_rd_address)) |
                     (id_uses_rs2 & (id_rs2_address == ex_rd_address)));

    // A wait state releases on its completion event; an op already accepted
    // must not be re-accepted when the held ex_mc_start is seen again.
    always_comb begin
        released = 1'b1;
        mc_ok    = 1'b1;
        unique case (state)
            MC_WAIT:  begin released = ex_mc_done; mc_ok = 1'b0;      end
            MEM_WAIT: begin released = mem_ready;  mc_ok = ~mc_taken; end
            default:  ;
        endcase
    end

    // NOTE: every signal gets its default before any branch so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        refill_cnt_nxt = refill_cnt;
        mc_taken_nxt   = 1'b0;
        lu_taken       = 1'b0;
        pc_w           = 1'b1;
        if_id_w        = 1'b1;
        id_ex_w        = 1'b1;
        ex_mem_w       = 1'b1;
        if_id_f        = 1'b0;
        id_ex_f        = 1'b0;

        if (!released || mem_stall) begin
            {pc_w, if_id_w, id_ex_w, ex_mem_w} = 4'b0000;
            if (released)
                state_nxt = MEM_WAIT;
            mc_taken_nxt = (state == MC_WAIT) || ((state == MEM_WAIT) && mc_taken);
        end else if (mc_ok && ex_mc_start && !ex_mc_done) begin
            {pc_w, if_id_w, id_ex_w, ex_mem_w} = 4'b0000;
            state_nxt = MC_WAIT;
        end else if (ex_redirect) begin
            if_id_f        = 1'b1;
            id_ex_f        = 1'b1;
            refill_cnt_nxt = RCW'(FETCH_LATENCY);
            state_nxt      = (FETCH_LATENCY > 0) ? REFILL : RUN;
        end else begin
            if (hazard && !lu_block) begin
                lu_taken = 1'b1;
                pc_w     = 1'b0;
                if_id_w  = 1'b0;
                id_ex_f  = 1'b1;
            end
            // IF/ID keeps loading NOPs until the post-redirect fetch arrives.
            if_id_f = refill_active;
            if (refill_active) begin
                refill_cnt_nxt = refill_cnt - RCW'(1);
                state_nxt      = (refill_cnt == RCW'(1)) ? RUN : REFILL;
            end else begin
                state_nxt = RUN;
            end
        end

        // The bubble just inserted sits in EX until the pipe next advances.
        lu_block_nxt = lu_taken | (lu_block & ~ex_mem_w);
    end

    always_comb begin
        if (!reset_n)
            {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, if_id_flush, id_ex_flush} = 6'b000011;
        else
            {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, if_id_flush, id_ex_flush} =
                {pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            refill_cnt <= '0;
            mc_taken   <= 1'b0;
            lu_block   <= 1'b0;
        end else begin
            state      <= state_nxt;
            refill_cnt <= refill_cnt_nxt;
            mc_taken   <= mc_taken_nxt;
            lu_block   <= lu_block_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_w)
                stall_q <= stall_q + CNT_WIDTH'(1);
            if (if_id_f)
                flush_q <= flush_q + CNT_WIDTH'(1);
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed hazard scenarios plus randomized cycles checked against a cycle-level reference model.
module tb_pipeline_hazard_controller;

    localparam int RAW = 5;
    localparam int FL  = 1;
    localparam int CW  = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [RAW-1:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic           id_uses_rs1, id_uses_rs2, ex_reg_wren, ex_is_load, ex_redirect;
    logic           ex_mc_start, ex_mc_done, mem_req, mem_ready;
    logic           pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, if_id_flush, id_ex_flush;
    logic [CW-1:0]  perf_stall_cnt, perf_flush_cnt;
    logic [5:0]     ctl;

    int tests_run = 0;
    int tests_failed = 0;

    pipeline_hazard_controller #(.REG_ADDR_WIDTH(RAW), .FETCH_LATENCY(FL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_address(ex_rd_address), .ex_reg_wren(ex_reg_wren), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_wren(pc_wren), .if_id_wren(if_id_wren), .id_ex_wren(id_ex_wren), .ex_mem_wren(ex_mem_wren),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc, if_id, id_ex, ex_mem wren, if_id flush, id_ex flush}
    assign ctl = {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, if_id_flush, id_ex_flush};

    // Reference model: which event froze the pipe (0 none, 1 memory, 2 multi-cycle),
    // how many refill cycles remain, whether the frozen EX op was already started,
    // and whether the previous advance inserted a load-use bubble.
    int         frozen_by, refill_left, n_frozen_by, n_refill_left;
    bit         mc_consumed, bubble_prev, n_mc_consumed, n_bubble_prev;
    logic [5:0] exp_ctl;
    logic [CW-1:0] m_stall, m_flush, exp_s, exp_f;

    task model_reset();
        frozen_by = 0; refill_left = 0; mc_consumed = 0; bubble_prev = 0;
        m_stall = '0; m_flush = '0;
    endtask

    task model_eval();
        bit mem_stall, released, mc_ok, hazard, lu;
        mem_stall = mem_req && !mem_ready;
        released  = (frozen_by == 0) || (frozen_by == 1 && mem_ready) || (frozen_by == 2 && ex_mc_done);
        mc_ok     = (frozen_by == 0) || (frozen_by == 1 && !mc_consumed);
        hazard    = ex_is_load && ex_reg_wren && ex_rd_address != 0 &&
                    ((id_uses_rs1 && id_rs1_address == ex_rd_address) ||
                     (id_uses_rs2 && id_rs2_address == ex_rd_address));
        lu = 0;
        n_frozen_by = frozen_by; n_refill_left = refill_left; n_mc_consumed = 0;
        if (!released || mem_stall) begin
            exp_ctl = 6'b000000;
            if (released) n_frozen_by = 1;
            n_mc_consumed = (frozen_by == 2) || (frozen_by == 1 && mc_consumed);
        end else if (mc_ok && ex_mc_start && !ex_mc_done) begin
            exp_ctl = 6'b000000;
            n_frozen_by = 2;
        end else if (ex_redirect) begin
            exp_ctl = 6'b111111;
            n_frozen_by = 0;
            n_refill_left = FL;
        end else begin
            lu = hazard && !bubble_prev;
            exp_ctl = lu ? 6'b001101 : 6'b111100;
            if (refill_left > 0) begin
                exp_ctl[1] = 1'b1;
                n_refill_left = refill_left - 1;
            end
            n_frozen_by = 0;
        end
        n_bubble_prev = lu ? 1'b1 : (exp_ctl[2] ? 1'b0 : bubble_prev);
    endtask

    task model_commit();
        if (!reset_n) begin
            model_reset();
        end else begin
            if (!exp_ctl[5]) m_stall++;
            if (exp_ctl[1])  m_flush++;
            frozen_by = n_frozen_by; refill_left = n_refill_left;
            mc_consumed = n_mc_consumed; bubble_prev = n_bubble_prev;
        end
    endtask

    task perf_expect();
`ifdef HAZARD_PERF_EN
        exp_s = m_stall; exp_f = m_flush;
`else
        exp_s = '0; exp_f = '0;
`endif
    endtask

    // Called at a negedge+1 point after inputs are settled; returns at the next negedge.
    task step();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task idle();
        id_rs1_address = '0; id_rs2_address = '0; ex_rd_address = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_reg_wren = 0; ex_is_load = 0; ex_redirect = 0;
        ex_mc_start = 0; ex_mc_done = 0; mem_req = 0; mem_ready = 0;
    endtask

    task test_reset();
        idle();
        model_reset();
        #2;
        tests_run++; if (ctl !== 6'b000011) begin tests_failed++; $display("FAIL reset_outputs: got %b want %b", ctl, 6'b000011); end
        tests_run++; if ((perf_stall_cnt | perf_flush_cnt) !== '0) begin tests_failed++; $display("FAIL reset_counters: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL run_after_reset: got %b want %b", ctl, 6'b111100); end
        step();
    endtask

    task test_load_use();
        idle(); ex_is_load = 1; ex_reg_wren = 1; ex_rd_address = 5; id_rs1_address = 5; id_uses_rs1 = 1;
        #1;
        tests_run++; if (ctl !== 6'b001101) begin tests_failed++; $display("FAIL load_use_rs1: got %b want %b", ctl, 6'b001101); end
        step();
        #1;   // hazard inputs still present: only one bubble may be inserted
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL load_use_single_bubble: got %b want %b", ctl, 6'b111100); end
        step();
        idle(); #1; step();
        ex_is_load = 1; ex_reg_wren = 1; ex_rd_address = 7; id_rs2_address = 7; id_uses_rs2 = 1;
        #1;
        tests_run++; if (ctl !== 6'b001101) begin tests_failed++; $display("FAIL load_use_rs2: got %b want %b", ctl, 6'b001101); end
        step();
        idle(); #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL load_use_release: got %b want %b", ctl, 6'b111100); end
        step();
    endtask

    task test_no_hazard();
        idle(); ex_is_load = 1; ex_reg_wren = 1; ex_rd_address = 0; id_rs1_address = 0; id_uses_rs1 = 1;
        #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL x0_no_stall: got %b want %b", ctl, 6'b111100); end
        step();
        ex_rd_address = 5; id_rs1_address = 3; id_rs2_address = 5; id_uses_rs2 = 0;
        #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL unused_rs2_no_stall: got %b want %b", ctl, 6'b111100); end
        step();
        ex_reg_wren = 0; id_rs1_address = 5;
        #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL no_wren_no_stall: got %b want %b", ctl, 6'b111100); end
        step();
        idle();
    endtask

    task test_redirect();
        idle(); ex_redirect = 1; #1;
        tests_run++; if (ctl !== 6'b111111) begin tests_failed++; $display("FAIL redirect_cycle: got %b want %b", ctl, 6'b111111); end
        step();
        ex_redirect = 0; #1;
        tests_run++; if (ctl !== 6'b111110) begin tests_failed++; $display("FAIL refill_cycle: got %b want %b", ctl, 6'b111110); end
        step();
        #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL after_refill: got %b want %b", ctl, 6'b111100); end
        step();
        ex_redirect = 1; #1; step();
        #1;   // redirect arriving during refill restarts it
        tests_run++; if (ctl !== 6'b111111) begin tests_failed++; $display("FAIL redirect_in_refill: got %b want %b", ctl, 6'b111111); end
        step();
        ex_redirect = 0; #1;
        tests_run++; if (ctl !== 6'b111110) begin tests_failed++; $display("FAIL refill_restarted: got %b want %b", ctl, 6'b111110); end
        step();
        idle(); #1; step();
    endtask

    task test_multicycle();
        logic [CW-1:0] s0;
        idle(); ex_mc_start = 1;
        #1; s0 = perf_stall_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) #1;
            tests_run++; if (ctl !== 6'b000000) begin tests_failed++; $display("FAIL mc_freeze[%0d]: got %b want %b", i, ctl, 6'b000000); end
            step();
        end
        ex_mc_done = 1; #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL mc_done_release: got %b want %b", ctl, 6'b111100); end
        step();
        ex_mc_done = 0; ex_mc_start = 0; #1;
        s0 = perf_stall_cnt - s0;
`ifdef HAZARD_PERF_EN
        tests_run++; if (s0 !== CW'(5)) begin tests_failed++; $display("FAIL mc_stall_count: got %0d want 5", s0); end
`else
        tests_run++; if (perf_stall_cnt !== '0) begin tests_failed++; $display("FAIL mc_stall_count_tied: got %0d want 0", perf_stall_cnt); end
`endif
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL mc_after_done: got %b want %b", ctl, 6'b111100); end
        step();
    endtask

    task test_mem_redirect();
        idle(); mem_req = 1; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (ctl !== 6'b000000) begin tests_failed++; $display("FAIL mem_freeze[%0d]: got %b want %b", i, ctl, 6'b000000); end
            step();
        end
        mem_ready = 1; #1;
        tests_run++; if (ctl !== 6'b111111) begin tests_failed++; $display("FAIL mem_release_flush: got %b want %b", ctl, 6'b111111); end
        step();
        idle(); #1;
        tests_run++; if (ctl !== 6'b111110) begin tests_failed++; $display("FAIL mem_release_refill: got %b want %b", ctl, 6'b111110); end
        step();
        #1; step();
    endtask

    task test_mc_then_mem();
        idle(); ex_mc_start = 1; #1; step();
        mem_req = 1; #1;
        tests_run++; if (ctl !== 6'b000000) begin tests_failed++; $display("FAIL mc_mem_overlap: got %b want %b", ctl, 6'b000000); end
        step();
        ex_mc_done = 1; #1;
        tests_run++; if (ctl !== 6'b000000) begin tests_failed++; $display("FAIL mc_done_mem_stalled: got %b want %b", ctl, 6'b000000); end
        step();
        ex_mc_done = 0; mem_ready = 1; #1;   // ex_mc_start still held: must not restart
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL mem_release_no_mc_repeat: got %b want %b", ctl, 6'b111100); end
        step();
        idle(); #1; step();
    endtask

    task test_reset_mid_mc();
        idle(); ex_mc_start = 1; #1; step();
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++; if (ctl !== 6'b000011) begin tests_failed++; $display("FAIL async_reset_outputs: got %b want %b", ctl, 6'b000011); end
        model_reset();
        @(posedge clk); @(negedge clk);
        idle(); reset_n = 1'b1; #1;
        tests_run++; if (ctl !== 6'b111100) begin tests_failed++; $display("FAIL run_after_mid_reset: got %b want %b", ctl, 6'b111100); end
        tests_run++; if ((perf_stall_cnt | perf_flush_cnt) !== '0) begin tests_failed++; $display("FAIL counters_after_mid_reset: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt); end
        step();
    endtask

    task test_random();
        for (int i = 0; i < 600; i++) begin
            ex_rd_address  = RAW'($urandom_range(0, 3));
            id_rs1_address = RAW'($urandom_range(0, 3));
            id_rs2_address = RAW'($urandom_range(0, 3));
            id_uses_rs1 = ($urandom_range(0, 1) == 1);
            id_uses_rs2 = ($urandom_range(0, 1) == 1);
            ex_reg_wren = ($urandom_range(0, 3) != 0);
            ex_is_load  = ($urandom_range(0, 2) == 0);
            ex_redirect = ($urandom_range(0, 6) == 0);
            ex_mc_start = ($urandom_range(0, 7) == 0);
            ex_mc_done  = ($urandom_range(0, 3) == 0);
            mem_req     = ($urandom_range(0, 4) == 0);
            mem_ready   = ($urandom_range(0, 2) == 0);
            #1;
            model_eval();
            perf_expect();
            tests_run++; if (ctl !== exp_ctl) begin tests_failed++; $display("FAIL random_ctl[%0d]: got %b want %b", i, ctl, exp_ctl); end
            tests_run++; if (perf_stall_cnt !== exp_s || perf_flush_cnt !== exp_f) begin
                tests_failed++; $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d", i, perf_stall_cnt, perf_flush_cnt, exp_s, exp_f);
            end
            step();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_multicycle();
        test_mem_redirect();
        test_mc_then_mem();
        test_reset_mid_mc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
